// File: rtl/datapath_pkg.sv
// Shared definitions for the accumulator datapath and its controller:
// ALU operation codes, command opcodes and the controller state encoding.
package datapath_pkg;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_SHR  = 3'b101;
  localparam logic [2:0] ALU_ZERO = 3'b111;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_MUL   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_ADD       = 3'd2,
    S_CLEAR     = 3'd3,
    S_MUL_INIT  = 3'd4,
    S_MUL_ADD   = 3'd5,
    S_MUL_SHIFT = 3'd6,
    S_DONE      = 3'd7
  } state_e;

endpackage

// File: rtl/datapath_controller.sv
// Sequences LOAD/ADD/CLEAR (2 cycles to done) and shift-add MUL (2*WIDTH+2 cycles to done)
// by driving datapath selects; start is only accepted in IDLE, never queued or aborting.
module datapath_controller
  import datapath_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       q_lsb,
  output logic       busy,
  output logic       done,
  output logic       mux_2x1_R1_sel,
  output logic       mux_2x1_alu_a_sel,
  output logic       mux_2x1_acc_sel,
  output logic       acc_load_sel,
  output logic       q_dir_sel,
  output logic [2:0] alu_control
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    busy              = 1'b1;
    done              = 1'b0;
    mux_2x1_R1_sel    = 1'b0;
    mux_2x1_alu_a_sel = 1'b0;
    mux_2x1_acc_sel   = 1'b0;
    acc_load_sel      = 1'b0;
    q_dir_sel         = 1'b0;
    alu_control       = ALU_PASS;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          case (op)
            OP_LOAD: state_d = S_LOAD;
            OP_ADD:  state_d = S_ADD;
            OP_MUL:  state_d = S_MUL_INIT;
            default: state_d = S_CLEAR;
          endcase
        end
      end
      S_LOAD: begin
        mux_2x1_R1_sel = 1'b1;
        state_d        = S_DONE;
      end
      S_ADD: begin
        alu_control  = ALU_ADD;
        acc_load_sel = 1'b1;
        state_d      = S_DONE;
      end
      S_CLEAR: begin
        alu_control  = ALU_ZERO;
        acc_load_sel = 1'b1;
        state_d      = S_DONE;
      end
      S_MUL_INIT: begin
        alu_control  = ALU_ZERO;
        acc_load_sel = 1'b1;
        cnt_d        = CNT_W'(WIDTH - 1);
        state_d      = S_MUL_ADD;
      end
      S_MUL_ADD: begin
        // Only Mealy output: add R1 into ACC when the multiplier bit is set.
        alu_control  = ALU_ADD;
        acc_load_sel = q_lsb;
        state_d      = S_MUL_SHIFT;
      end
      S_MUL_SHIFT: begin
        alu_control  = ALU_SHR;
        acc_load_sel = 1'b1;
        q_dir_sel    = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = S_MUL_ADD;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_datapath_controller.sv
// Scoreboard bench: stimulus queues per-cycle expected control vectors, a negedge monitor
// compares every busy cycle against the queue and checks the safe vector in IDLE.
module tb_datapath_controller;
  import datapath_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic       q_lsb;
  logic       busy, done, mux_2x1_R1_sel, mux_2x1_alu_a_sel, mux_2x1_acc_sel;
  logic       acc_load_sel, q_dir_sel;
  logic [2:0] alu_control;

  always #5 clk = ~clk;

  datapath_controller #(.WIDTH(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .op                (op),
    .q_lsb             (q_lsb),
    .busy              (busy),
    .done              (done),
    .mux_2x1_R1_sel    (mux_2x1_R1_sel),
    .mux_2x1_alu_a_sel (mux_2x1_alu_a_sel),
    .mux_2x1_acc_sel   (mux_2x1_acc_sel),
    .acc_load_sel      (acc_load_sel),
    .q_dir_sel         (q_dir_sel),
    .alu_control       (alu_control)
  );

  // Behavioural 4-bit accumulator datapath driven by the controller outputs.
  logic [3:0] r1_m = '0, acc_m = '0, q_m = '0, din = '0, q_init = '0, alu_a, alu_y;
  logic       q_load = 1'b0;

  assign q_lsb = q_m[0];
  assign alu_a = mux_2x1_alu_a_sel ? r1_m : acc_m;

  always_comb begin
    alu_y = alu_a;
    case (alu_control)
      ALU_ADD:  alu_y = alu_a + r1_m;
      ALU_SUB:  alu_y = alu_a - r1_m;
      ALU_SHR:  alu_y = alu_a >> 1;
      ALU_ZERO: alu_y = 4'd0;
      default:  alu_y = alu_a;
    endcase
  end

  always @(posedge clk) begin
    if (mux_2x1_R1_sel) r1_m <= din;
    if (acc_load_sel)   acc_m <= mux_2x1_acc_sel ? din : alu_y;
    if (q_load)         q_m <= q_init;
    else if (q_dir_sel) q_m <= {acc_m[0], q_m[3:1]};
  end

  typedef struct packed {
    logic       busy, done, r1, alu_a, acc_sel, acc_load, q_dir;
    logic [2:0] alu;
  } outv_t;

  typedef struct {
    int         cyc;
    outv_t      v;
    bit         chk;
    logic [7:0] prod;
  } exp_t;

  exp_t  expq[$];
  outv_t act;
  int    cyc = 0;
  int    ncmp = 0;
  int    nerr = 0;
  bit    mon_en = 1'b0;

  assign act = {busy, done, mux_2x1_R1_sel, mux_2x1_alu_a_sel, mux_2x1_acc_sel,
                acc_load_sel, q_dir_sel, alu_control};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic outv_t mk(input logic b, d, r1, aa, as, al, qd, input logic [2:0] alu);
    outv_t v;
    v = {b, d, r1, aa, as, al, qd, alu};
    return v;
  endfunction

  localparam outv_t SAFE = {7'b0000000, ALU_PASS};

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (busy) begin
        if (expq.size() == 0) begin
          ncmp++; nerr++;
          $display("FAIL unexpected_busy cyc=%0d got=%b required=idle", cyc, act);
        end else begin
          e = expq.pop_front();
          ncmp++;
          if (e.cyc != cyc || act !== e.v) begin
            nerr++;
            $display("FAIL ctrl_vec cyc=%0d got=%b required=%b at cyc=%0d", cyc, act, e.v, e.cyc);
          end
          if (e.chk) begin
            ncmp++;
            if ({acc_m, q_m} !== e.prod) begin
              nerr++;
              $display("FAIL product cyc=%0d got=%b required=%b", cyc, {acc_m, q_m}, e.prod);
            end
          end
        end
      end else begin
        ncmp++;
        if (act !== SAFE) begin
          nerr++;
          $display("FAIL idle_safe cyc=%0d got=%b required=%b", cyc, act, SAFE);
        end
        while (expq.size() > 0 && expq[0].cyc <= cyc) begin
          ncmp++; nerr++;
          $display("FAIL missing cyc=%0d got=idle required=%b", expq[0].cyc, expq[0].v);
          void'(expq.pop_front());
        end
      end
    end
  end

  task automatic add_exp(input int c, input outv_t v, input int lim, input bit chk,
                         input logic [7:0] prod);
    exp_t e;
    if (c <= lim) begin
      e.cyc = c; e.v = v; e.chk = chk; e.prod = prod;
      expq.push_back(e);
    end
  endtask

  // k is the cycle in which start is sampled; the command's first state is cycle k+1.
  task automatic push_cmd(input logic [1:0] o, input logic [3:0] pat, input int k,
                          input int lim, input bit chk, input logic [7:0] prod);
    int d;
    d = k + 2;
    case (o)
      OP_LOAD:  add_exp(k + 1, mk(1, 0, 1, 0, 0, 0, 0, ALU_PASS), lim, 0, '0);
      OP_ADD:   add_exp(k + 1, mk(1, 0, 0, 0, 0, 1, 0, ALU_ADD),  lim, 0, '0);
      OP_CLEAR: add_exp(k + 1, mk(1, 0, 0, 0, 0, 1, 0, ALU_ZERO), lim, 0, '0);
      default: begin
        add_exp(k + 1, mk(1, 0, 0, 0, 0, 1, 0, ALU_ZERO), lim, 0, '0);
        for (int i = 0; i < 4; i++) begin
          add_exp(k + 2 + 2 * i, mk(1, 0, 0, 0, 0, pat[i], 0, ALU_ADD), lim, 0, '0);
          add_exp(k + 3 + 2 * i, mk(1, 0, 0, 0, 0, 1, 1, ALU_SHR), lim, 0, '0);
        end
        d = k + 10;
      end
    endcase
    add_exp(d, mk(1, 1, 0, 0, 0, 0, 0, ALU_PASS), lim, chk, prod);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_q(input logic [3:0] v);
    q_init = v; q_load = 1'b1;
    tick();
    q_load = 1'b0;
  endtask

  localparam int NOLIM = 1 << 30;

  initial begin
    int k;
    tick(); tick();
    reset = 1'b0;
    mon_en = 1'b1;
    tick(); tick();

    // LOAD R1 = 3
    din = 4'd3; start = 1'b1; op = OP_LOAD;
    tick(); k = cyc - 1; start = 1'b0;
    push_cmd(OP_LOAD, 4'b0000, k, NOLIM, 0, '0);
    repeat (4) tick();

    // ADD then CLEAR with start held high
    start = 1'b1; op = OP_ADD;
    tick(); k = cyc - 1;
    push_cmd(OP_ADD, 4'b0000, k, NOLIM, 0, '0);
    push_cmd(OP_CLEAR, 4'b0000, k + 3, NOLIM, 0, '0);
    op = OP_CLEAR;
    repeat (3) tick();
    start = 1'b0;
    repeat (4) tick();

    // MUL 3 x 5: multiplier bits 1,0,1,0
    set_q(4'd5);
    start = 1'b1; op = OP_MUL;
    tick(); k = cyc - 1; start = 1'b0;
    push_cmd(OP_MUL, 4'b0101, k, NOLIM, 1, 8'h0F);
    repeat (12) tick();

    // MUL 3 x 6 with an ADD request pulsed mid-command, which must be ignored
    set_q(4'd6);
    start = 1'b1; op = OP_MUL;
    tick(); k = cyc - 1; start = 1'b0;
    push_cmd(OP_MUL, 4'b0110, k, NOLIM, 1, 8'h12);
    repeat (3) tick();
    start = 1'b1; op = OP_ADD;
    tick();
    start = 1'b0;
    repeat (10) tick();

    // Reset during the second MUL_SHIFT: abandon, no done pulse
    set_q(4'd5);
    start = 1'b1; op = OP_MUL;
    tick(); k = cyc - 1; start = 1'b0;
    push_cmd(OP_MUL, 4'b0101, k, k + 5, 0, '0);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (4) tick();

    // Recovery after reset
    start = 1'b1; op = OP_CLEAR;
    tick(); k = cyc - 1; start = 1'b0;
    push_cmd(OP_CLEAR, 4'b0000, k, NOLIM, 0, '0);
    repeat (5) tick();

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/datapath_controller.md
# datapath_controller

Control unit that drives the accumulator datapath's select and ALU-control lines from a small command interface. It sits between the sequencer or top level, which issues `start` with an opcode, and the `datapath` block, whose control inputs it owns. It sequences four commands, LOAD, ADD, CLEAR and a 4-bit shift-add MUL, with a fixed, deterministic cycle count per command and a busy/done handshake.

## Interface
Parameters:
- `WIDTH`, default 4: datapath word width. It sets the MUL iteration count.

Ports:
- `clk`  input  1: single clock. All state updates on the rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `start`  input  1: command request. Sampled only in IDLE.
- `op`  input  2: opcode, sampled with `start`. 00 = LOAD, 01 = ADD, 10 = MUL, 11 = CLEAR.
- `q_lsb`  input  1: datapath status, the current Q-register LSB. Used only in MUL_ADD.
- `busy`  output  1: high in every non-IDLE state.
- `done`  output  1: one-cycle pulse in DONE.
- `mux_2x1_R1_sel`  output  1: 1 = R1 captures `in`; 0 = R1 holds.
- `mux_2x1_alu_a_sel`  output  1: 0 = ALU A operand is ACC; 1 = ALU A operand is R1.
- `mux_2x1_acc_sel`  output  1: 0 = ACC input from the ALU; 1 = ACC input from `in`.
- `acc_load_sel`  output  1: 1 = ACC loads this edge.
- `q_dir_sel`  output  1: 1 = {ACC,Q} shift right by one this edge (Q takes ACC LSB); 0 = Q holds.
- `alu_control`  output  3: ALU operation code, using the package constants.

## Operation
- States: IDLE, LOAD, ADD, CLEAR, MUL_INIT, MUL_ADD, MUL_SHIFT, DONE.
- IDLE outputs are the "safe vector": every select 0, `acc_load_sel` 0, `q_dir_sel` 0, `alu_control` = ALU_PASS, `busy` 0, `done` 0. The safe vector is also the reset value of every output.
- IDLE transitions:
  - `start` = 1: go to LOAD, ADD, MUL_INIT or CLEAR per `op`.
  - Otherwise stay in IDLE.
- State actions (each lasts one cycle and goes to DONE unless stated):
  - LOAD: `mux_2x1_R1_sel` = 1.
  - ADD: `mux_2x1_alu_a_sel` = 0, `alu_control` = ALU_ADD, `mux_2x1_acc_sel` = 0, `acc_load_sel` = 1.
  - CLEAR: `alu_control` = ALU_ZERO, `acc_load_sel` = 1.
  - MUL_INIT: same outputs as CLEAR. Loads the iteration counter with `WIDTH`-1. Goes to MUL_ADD.
  - MUL_ADD: `alu_control` = ALU_ADD, `mux_2x1_alu_a_sel` = 0, `acc_load_sel` = `q_lsb`. This is the only Mealy output. Goes to MUL_SHIFT.
  - MUL_SHIFT: `alu_control` = ALU_SHR, `acc_load_sel` = 1, `q_dir_sel` = 1. If counter = 0, go to DONE; otherwise decrement the counter and go to MUL_ADD.
  - DONE: `done` = 1, `busy` = 1, all datapath controls at the safe vector. Goes to IDLE.
- The counter is `$clog2(WIDTH)` bits wide. It is never allowed to wrap, because exit is taken at 0.
- `start` outside IDLE is ignored; it is neither queued nor able to abort the current command.
- `start` held high is re-sampled in the first IDLE cycle after DONE, so back-to-back commands have one IDLE cycle between them.
- Reset asserted in any state forces IDLE and the safe vector on the next edge. A partial MUL is abandoned and `done` is not pulsed.
- Undefined or X `op` is not possible, since all four codes are defined. An unknown state decodes to IDLE with the safe vector.

## Timing
- `start` is sampled at edge k. The first command state is active from k+1.
- LOAD, ADD and CLEAR: 1 work cycle, then DONE at k+2, then IDLE at k+3.
- MUL: MUL_INIT at k+1, then `WIDTH` pairs of (MUL_ADD, MUL_SHIFT). For `WIDTH` = 4 that is k+2 through k+9, DONE at k+10 and IDLE at k+11.
- `busy` rises at k+1 and falls at the IDLE entry.
- All outputs except `acc_load_sel` in MUL_ADD are decoded from the state register only. They are valid by the first clock edge after the state changes plus combinational delay.

## Structure
- Shared package `datapath_pkg` holds:
  - the ALU codes: ALU_PASS = 000, ALU_ADD = 001, ALU_SUB = 010, ALU_SHR = 101, ALU_ZERO = 111;
  - the opcode constants;
  - the state encoding.
- The `datapath` ALU uses the same package.
- Single module with no sub-module. A state register plus a combinational output decoder is natural.
- Top-level integration wires `datapath_controller` directly to `datapath`.

## Test plan
- Reset mid-MUL: assert `reset` at k+5 → next edge IDLE, safe vector, `busy` = 0, no `done`.
- LOAD: `op` = 00, `start` pulse → `mux_2x1_R1_sel` = 1 for exactly one cycle at k+1; `done` at k+2; `busy` = 0 at k+3.
- ADD then CLEAR back-to-back with `start` held high → ADD at k+1, DONE at k+2, IDLE at k+3, CLEAR at k+4; `alu_control` = 001 then 111.
- MUL with `q_lsb` pattern 1, 0, 1, 0 → `acc_load_sel` in the four MUL_ADD cycles = 1, 0, 1, 0; `q_dir_sel` = 1 in four cycles; `done` at k+10.
- `start` with `op` = 01 pulsed during MUL (at k+4) → ignored; MUL timing unchanged; no ADD follows.
- Integrated with `datapath`, `WIDTH` = 4, R1 = 3, Q = 5 → {ACC,Q} = 0000_1111 after `done`.
